mux_rr_scheduler: RTL and testbench

//  Round-robin scheduler that shares the 4-way, 4-bit Multiplexer among four requesters.
//  It drives the mux select and enable, and returns a one-hot grant to each source.
//  A fairness quota limits how long one source keeps the mux, and a downstream

---
 rtl/mux_arb_pkg.sv | 22 ++
 rtl/rr_pick.sv | 22 ++
 rtl/mux_rr_scheduler.sv | 120 ++++++++++++
 tb/tb_mux_rr_scheduler.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the 4-source round-robin mux scheduler.
package mux_arb_pkg;

  localparam int NUM_SRC = 4;
  localparam int SEL_W   = 2;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // Index of the set bit in a one-hot vector; zero vector maps to index 0.
  function automatic logic [SEL_W-1:0] rr_onehot2idx(input logic [NUM_SRC-1:0] oh);
    logic [SEL_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (oh[i]) idx = idx | SEL_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request scanning ptr, ptr+1, .. mod 4.
module rr_pick
  import mux_arb_pkg::*;
(
  input  logic [NUM_SRC-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic [SEL_W-1:0]   idx,
  output logic               any
);

  logic [2*NUM_SRC-1:0] req_dbl;
  logic [NUM_SRC-1:0]   rot;
  logic [NUM_SRC-1:0]   first_oh;

  // Rotate so the pointer position lands at bit 0, then isolate the lowest set bit.
  assign req_dbl  = {req, req};
  assign rot      = req_dbl[ptr +: NUM_SRC];
  assign first_oh = rot & (~rot + 1'b1);
  assign idx      = ptr + rr_onehot2idx(first_oh);
  assign any      = |req;

endmodule

// File: rtl/mux_rr_scheduler.sv
// Round-robin owner of a 4-way mux: grant 1 cycle after req, one idle bubble between grants,
// out_ready low stalls the grant; ARB_LOCK_EN lets the owner hold past the beat quota.
module mux_rr_scheduler
  import mux_arb_pkg::*;
#(
  parameter  int HOLD_MAX = 4,
  localparam int CNT_W    = $clog2(HOLD_MAX + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] req,
  input  logic               out_ready,
  input  logic               lock,
  output logic [SEL_W-1:0]   sel,
  output logic               mux_en,
  output logic [NUM_SRC-1:0] gnt,
  output logic [CNT_W-1:0]   beat_cnt
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(HOLD_MAX);

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [NUM_SRC-1:0] gnt_q, gnt_d;
  logic               mux_en_q, mux_en_d;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;

  logic [SEL_W-1:0]   pick_idx;
  logic               pick_any;
  logic               lock_eff;
  logic               beat;
  logic               release_grant;

  rr_pick u_pick (
    .req (req),
    .ptr (ptr_q),
    .idx (pick_idx),
    .any (pick_any)
  );

`ifdef ARB_LOCK_EN
  assign lock_eff = lock;
`else
  logic unused_lock;
  assign unused_lock = lock;
  assign lock_eff    = 1'b0;
`endif

  assign beat = mux_en_q & out_ready;

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    sel_d         = sel_q;
    gnt_d         = gnt_q;
    mux_en_d      = mux_en_q;
    beat_cnt_d    = beat_cnt_q;
    release_grant = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d    = GRANT;
          sel_d      = pick_idx;
          gnt_d      = NUM_SRC'(1) << pick_idx;
          mux_en_d   = 1'b1;
          beat_cnt_d = '0;
        end
      end
      GRANT: begin
        // A dropped request ends the grant without counting the beat.
        if (!req[sel_q]) begin
          release_grant = 1'b1;
        end else if (beat) begin
          if ((beat_cnt_q >= CNT_LAST) && !lock_eff) begin
            release_grant = 1'b1;
          end else if (beat_cnt_q != CNT_MAX) begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
        if (release_grant) begin
          state_d    = IDLE;
          gnt_d      = '0;
          mux_en_d   = 1'b0;
          beat_cnt_d = '0;
          ptr_d      = sel_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      sel_q      <= '0;
      gnt_q      <= '0;
      mux_en_q   <= 1'b0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      sel_q      <= sel_d;
      gnt_q      <= gnt_d;
      mux_en_q   <= mux_en_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign sel      = sel_q;
  assign mux_en   = mux_en_q;
  assign gnt      = gnt_q;
  assign beat_cnt = beat_cnt_q;

endmodule

// File: tb/tb_mux_rr_scheduler.sv
// Bench for mux_rr_scheduler: vector table, corner sequences, random run against a reference model.
module tb_mux_rr_scheduler;

  localparam int HOLD_MAX = 4;
  localparam int CNT_W    = $clog2(HOLD_MAX + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       req;
  logic             out_ready;
  logic             lock;
  logic [1:0]       sel;
  logic             mux_en;
  logic [3:0]       gnt;
  logic [CNT_W-1:0] beat_cnt;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state: owner index (-1 when idle), beats taken, rr pointer, last select.
  int m_owner = -1;
  int m_beats = 0;
  int m_ptr   = 0;
  int m_sel   = 0;

  always #5 clk = ~clk;

  mux_rr_scheduler #(.HOLD_MAX(HOLD_MAX)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .out_ready (out_ready),
    .lock      (lock),
    .sel       (sel),
    .mux_en    (mux_en),
    .gnt       (gnt),
    .beat_cnt  (beat_cnt)
  );

  typedef struct {
    logic             rst;
    logic [3:0]       req;
    logic             rdy;
    logic [1:0]       sel;
    logic             en;
    logic [3:0]       gnt;
    logic [CNT_W-1:0] cnt;
  } vec_t;

  vec_t tbl [22];

  task automatic check(input string name, input logic [1:0] e_sel, input logic e_en,
                       input logic [3:0] e_gnt, input logic [CNT_W-1:0] e_cnt);
    vectors++;
    if (sel !== e_sel || mux_en !== e_en || gnt !== e_gnt || beat_cnt !== e_cnt) begin
      miscompares++;
      $display("FAIL %s @%0t: got sel=%0d en=%b gnt=%b cnt=%0d, want sel=%0d en=%b gnt=%b cnt=%0d",
               name, $time, sel, mux_en, gnt, beat_cnt, e_sel, e_en, e_gnt, e_cnt);
    end
  endtask

  task automatic model_release();
    m_ptr   = (m_owner + 1) % 4;
    m_owner = -1;
    m_beats = 0;
  endtask

  task automatic model_update();
    bit lk;
    bit found;
`ifdef ARB_LOCK_EN
    lk = lock;
`else
    lk = 1'b0;
`endif
    if (rst) begin
      m_owner = -1;
      m_beats = 0;
      m_ptr   = 0;
      m_sel   = 0;
    end else if (m_owner < 0) begin
      found = 1'b0;
      for (int k = 0; k < 4; k++) begin
        int i;
        i = (m_ptr + k) % 4;
        if (!found && req[i]) begin
          found   = 1'b1;
          m_owner = i;
          m_sel   = i;
          m_beats = 0;
        end
      end
    end else if (!req[m_owner]) begin
      model_release();
    end else if (out_ready) begin
      m_beats++;
      if (m_beats >= HOLD_MAX && !lk) model_release();
      else if (m_beats > HOLD_MAX) m_beats = HOLD_MAX;
    end
  endtask

  task automatic check_model(input string name);
    check(name, 2'(m_sel), (m_owner >= 0),
          (m_owner >= 0) ? 4'(1 << m_owner) : 4'd0, CNT_W'(m_beats));
  endtask

  // Apply the currently driven inputs across one rising edge; outputs are read 1 time unit later.
  task automatic step();
    model_update();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req = 4'hF; out_ready = 1'b1; lock = 1'b0;

    tbl[0]  = '{1'b1, 4'hF, 1'b1, 2'd0, 1'b0, 4'h0, CNT_W'(0)};
    tbl[1]  = '{1'b1, 4'hF, 1'b1, 2'd0, 1'b0, 4'h0, CNT_W'(0)};
    tbl[2]  = '{1'b0, 4'h4, 1'b1, 2'd2, 1'b1, 4'h4, CNT_W'(0)};
    tbl[3]  = '{1'b0, 4'h4, 1'b1, 2'd2, 1'b1, 4'h4, CNT_W'(1)};
    tbl[4]  = '{1'b0, 4'h4, 1'b1, 2'd2, 1'b1, 4'h4, CNT_W'(2)};
    tbl[5]  = '{1'b0, 4'h4, 1'b1, 2'd2, 1'b1, 4'h4, CNT_W'(3)};
    tbl[6]  = '{1'b0, 4'h4, 1'b1, 2'd2, 1'b0, 4'h0, CNT_W'(0)};
    tbl[7]  = '{1'b0, 4'h4, 1'b1, 2'd2, 1'b1, 4'h4, CNT_W'(0)};
    tbl[8]  = '{1'b0, 4'h0, 1'b1, 2'd2, 1'b0, 4'h0, CNT_W'(0)};
    tbl[9]  = '{1'b0, 4'h2, 1'b1, 2'd1, 1'b1, 4'h2, CNT_W'(0)};
    tbl[10] = '{1'b0, 4'hA, 1'b1, 2'd1, 1'b1, 4'h2, CNT_W'(1)};
    tbl[11] = '{1'b0, 4'hA, 1'b1, 2'd1, 1'b1, 4'h2, CNT_W'(2)};
    tbl[12] = '{1'b0, 4'h8, 1'b1, 2'd1, 1'b0, 4'h0, CNT_W'(0)};
    tbl[13] = '{1'b0, 4'h8, 1'b1, 2'd3, 1'b1, 4'h8, CNT_W'(0)};
    tbl[14] = '{1'b0, 4'h0, 1'b1, 2'd3, 1'b0, 4'h0, CNT_W'(0)};
    tbl[15] = '{1'b0, 4'h0, 1'b1, 2'd3, 1'b0, 4'h0, CNT_W'(0)};
    tbl[16] = '{1'b0, 4'h1, 1'b1, 2'd0, 1'b1, 4'h1, CNT_W'(0)};
    tbl[17] = '{1'b0, 4'h0, 1'b1, 2'd0, 1'b0, 4'h0, CNT_W'(0)};
    tbl[18] = '{1'b0, 4'h4, 1'b1, 2'd2, 1'b1, 4'h4, CNT_W'(0)};
    tbl[19] = '{1'b0, 4'h4, 1'b1, 2'd2, 1'b1, 4'h4, CNT_W'(1)};
    tbl[20] = '{1'b1, 4'h4, 1'b1, 2'd0, 1'b0, 4'h0, CNT_W'(0)};
    tbl[21] = '{1'b0, 4'h3, 1'b1, 2'd0, 1'b1, 4'h1, CNT_W'(0)};

    for (int v = 0; v < 22; v++) begin
      rst = tbl[v].rst; req = tbl[v].req; out_ready = tbl[v].rdy;
      step();
      check($sformatf("table[%0d]", v), tbl[v].sel, tbl[v].en, tbl[v].gnt, tbl[v].cnt);
    end

    // Rotation with all sources requesting: 4 beats per grant, then one bubble.
    rst = 1'b1; step(); check("rot_reset", 2'd0, 1'b0, 4'h0, CNT_W'(0));
    rst = 1'b0; req = 4'hF; out_ready = 1'b1;
    for (int g = 0; g < 5; g++) begin
      for (int k = 0; k < HOLD_MAX; k++) begin
        step();
        check("rotation", 2'(g % 4), 1'b1, 4'(1 << (g % 4)), CNT_W'(k));
      end
      step();
      check("rot_bubble", 2'(g % 4), 1'b0, 4'h0, CNT_W'(0));
    end

    // Long stall: count frozen, quota still four beats afterwards.
    rst = 1'b1; step(); check("stall_reset", 2'd0, 1'b0, 4'h0, CNT_W'(0));
    rst = 1'b0; req = 4'h1; out_ready = 1'b0;
    step(); check("stall_grant", 2'd0, 1'b1, 4'h1, CNT_W'(0));
    repeat (10) begin
      step(); check("stall_hold", 2'd0, 1'b1, 4'h1, CNT_W'(0));
    end
    out_ready = 1'b1;
    for (int k = 1; k < HOLD_MAX; k++) begin
      step(); check("stall_resume", 2'd0, 1'b1, 4'h1, CNT_W'(k));
    end
    step(); check("stall_release", 2'd0, 1'b0, 4'h0, CNT_W'(0));

    // Owner asserts lock across seven beats.
    rst = 1'b1; step(); check("lock_reset", 2'd0, 1'b0, 4'h0, CNT_W'(0));
    rst = 1'b0; req = 4'h1; out_ready = 1'b1; lock = 1'b1;
    step(); check("lock_grant", 2'd0, 1'b1, 4'h1, CNT_W'(0));
`ifdef ARB_LOCK_EN
    for (int k = 1; k <= 7; k++) begin
      step(); check("lock_hold", 2'd0, 1'b1, 4'h1, CNT_W'((k > HOLD_MAX) ? HOLD_MAX : k));
    end
    lock = 1'b0;
    step(); check("lock_drop", 2'd0, 1'b0, 4'h0, CNT_W'(0));
`else
    for (int k = 1; k < HOLD_MAX; k++) begin
      step(); check("lock_ignored", 2'd0, 1'b1, 4'h1, CNT_W'(k));
    end
    step(); check("lock_quota", 2'd0, 1'b0, 4'h0, CNT_W'(0));
`endif
    lock = 1'b0;

    // Randomised traffic against the reference model.
    rst = 1'b1; step(); check_model("rand_reset");
    rst = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom % 100) == 0;
      for (int b = 0; b < 4; b++) begin
        if (($urandom % 6) == 0) req[b] = ~req[b];
      end
      out_ready = ($urandom % 4) != 0;
      if (($urandom % 16) == 0) lock = ~lock;
      step();
      check_model("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
